// File: rtl/sd_cmd_rx.sv
// sd_cmd_rx: SD command-line response receiver (48-bit R1/R3/R6/R7, 136-bit R2).
// Arms on en, waits up to TIMEOUT_CYCLES for a start bit, shifts the token in
// MSB first, then reports the fields with CRC7/framing/timeout status.
// Ports:
//   clk, reset         sd_clk (sd_cmd sampled on posedge), async active-low reset
//   en                 arm request, honoured only when idle
//   long_resp          1 = 136-bit R2, 0 = 48-bit token (latched at en)
//   check_crc          0 = skip CRC check (latched at en)
//   sd_cmd             serial command line from the card (idles high)
//   receiving          high while waiting for / shifting in a token
//   resp_done          1-cycle pulse when a token completes or times out
//   resp_index/arg/long  decoded token fields
//   crc_err, frame_err, timeout  status flags
module sd_cmd_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         long_resp,
    input  logic         check_crc,
    input  logic         sd_cmd,
    output logic         receiving,
    output logic         resp_done,
    output logic [5:0]   resp_index,
    output logic [31:0]  resp_arg,
    output logic [119:0] resp_long,
    output logic         crc_err,
    output logic         frame_err,
    output logic         timeout
);

    localparam int unsigned SHORT_LEN = 48;
    localparam int unsigned LONG_LEN  = 136;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        RECV       = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t             state;
    logic               long_q;
    logic               chk_q;
    logic               to_hit;
    logic [LONG_LEN-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [6:0]         crc;
    logic [TO_W-1:0]    to_cnt;

    logic [CNT_W-1:0]   bit_num;
    logic [CNT_W-1:0]   tok_len;
    logic               crc_on;
    logic [TO_W-1:0]    to_cnt_nxt;

    // One serial CRC7 step, polynomial x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Position of the bit being sampled (1 = start bit) and CRC coverage window
    always_comb begin
        bit_num    = bit_cnt + CNT_W'(1);
        tok_len    = long_q ? CNT_W'(LONG_LEN) : CNT_W'(SHORT_LEN);
        crc_on     = 1'b0;
        to_cnt_nxt = to_cnt + TO_W'(1);
        if (long_q) begin
            crc_on = (bit_num >= CNT_W'(9)) && (bit_num <= CNT_W'(128));
        end else begin
            crc_on = (bit_num >= CNT_W'(2)) && (bit_num <= CNT_W'(40));
        end
    end

    // Receive FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            long_q     <= 1'b0;
            chk_q      <= 1'b0;
            to_hit     <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            crc        <= '0;
            to_cnt     <= '0;
            receiving  <= 1'b0;
            resp_done  <= 1'b0;
            resp_index <= '0;
            resp_arg   <= '0;
            resp_long  <= '0;
            crc_err    <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            resp_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        long_q     <= long_resp;
                        chk_q      <= check_crc;
                        to_hit     <= 1'b0;
                        to_cnt     <= '0;
                        receiving  <= 1'b1;
                        resp_index <= '0;
                        resp_arg   <= '0;
                        resp_long  <= '0;
                        crc_err    <= 1'b0;
                        frame_err  <= 1'b0;
                        timeout    <= 1'b0;
                        state      <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    // A start bit on the last allowed sample beats the timeout
                    if (!sd_cmd) begin
                        shreg   <= '0;
                        bit_cnt <= CNT_W'(1);
                        crc     <= '0;
                        state   <= RECV;
                    end else begin
                        to_cnt <= to_cnt_nxt;
                        if (to_cnt_nxt == TO_W'(TIMEOUT_CYCLES)) begin
                            to_hit <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                RECV: begin
                    shreg   <= {shreg[LONG_LEN-2:0], sd_cmd};
                    bit_cnt <= bit_num;
                    if (crc_on) begin
                        crc <= crc7_step(crc, sd_cmd);
                    end
                    if (bit_num == tok_len) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    resp_done <= 1'b1;
                    receiving <= 1'b0;
                    state     <= IDLE;
                    if (to_hit) begin
                        timeout <= 1'b1;
                    end else begin
                        crc_err <= chk_q && (shreg[7:1] != crc);
                        if (long_q) begin
                            resp_index <= shreg[133:128];
                            resp_long  <= shreg[127:8];
                            frame_err  <= shreg[134] | ~shreg[0] | (shreg[133:128] != 6'h3F);
                        end else begin
                            resp_index <= shreg[45:40];
                            resp_arg   <= shreg[39:8];
                            frame_err  <= shreg[46] | ~shreg[0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
